data_mem_responder: RTL

- Data-memory responder on the far side of the CPU core's load/store interface.
- Takes the core's address (ALUResult), writeData and memWrite, and returns readData combinationally within the same cycle.
- Watches the core's finish flag. On its rising edge, a scan FSM walks every word and produces a 32-bit signature that the bench compares against a golden value.

---
 rtl/data_mem_responder_pkg.sv | 21 ++
 rtl/dmem_sig_scanner.sv | 93 +++++++++
 rtl/data_mem_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared definitions for the data-memory responder and its signature
//   scanner: default word width, byte-offset width of a word address and
//   the scan FSM state type.
// ----------------------------------------------------------------------------
package data_mem_responder_pkg;

  // Default data/address width of the core-facing port.
  localparam int WORD_W_DEFAULT  = 32;

  // Byte-offset bits below the word index in a byte address.
  localparam int DMEM_BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/dmem_sig_scanner.sv
// ----------------------------------------------------------------------------
// dmem_sig_scanner
//   Watches the core's finish flag. On its rising edge it walks every word of
//   the data array (through a dedicated read port) and accumulates
//   signature += mem[idx] ^ idx, one word per cycle. DONE is terminal until
//   reset.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   finish     in   core-halted flag
//   rd_data    in   mem[rd_idx] from the array's scan read port
//   rd_idx     out  word index presented to the scan read port
//   state      out  current FSM state (IDLE gates core stores)
//   dump_busy  out  high while the scan runs
//   dump_done  out  high once the scan has completed
//   signature  out  scan result
// ----------------------------------------------------------------------------
module dmem_sig_scanner
  import data_mem_responder_pkg::*;
#(
  parameter  int WORD   = WORD_W_DEFAULT,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              finish,
  input  logic [WORD-1:0]   rd_data,
  output logic [ADDR_W-1:0] rd_idx,
  output dump_state_t       state,
  output logic              dump_busy,
  output logic              dump_done,
  output logic [WORD-1:0]   signature
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  dump_state_t       r_state;
  logic              r_finish_q;
  logic [ADDR_W-1:0] r_idx;
  logic [WORD-1:0]   r_sig;
  logic              r_busy;
  logic              r_done;
  logic              w_start;

  // finish_q resets to 0, so finish already high out of reset starts one scan.
  assign w_start = finish & ~r_finish_q;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_finish_q <= 1'b0;
      r_idx      <= '0;
      r_sig      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_finish_q <= finish;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= SCAN;
            r_idx   <= '0;
            r_sig   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SCAN: begin
          // Sum wraps modulo 2^WORD; the index is zero-extended into the term.
          r_sig <= r_sig + (rd_data ^ {{(WORD - ADDR_W){1'b0}}, r_idx});
          r_idx <= r_idx + ADDR_W'(1);
          if (r_idx == LAST_IDX) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_idx    = r_idx;
  assign state     = r_state;
  assign dump_busy = r_busy;
  assign dump_done = r_done;
  assign signature = r_sig;

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   Data memory on the far side of the core's load/store interface. Reads are
//   combinational (zero latency, no store bypass); stores commit on the clock
//   edge while the scanner is IDLE. A finish rising edge launches a signature
//   scan over the whole array (see dmem_sig_scanner).
//
//   Optional feature, macro DMEM_ALIGN_CHECK_EN: when defined, any IDLE cycle
//   with addr[1:0] != 0 sets the sticky misaligned flag and misaligned stores
//   are suppressed. When undefined, misaligned is 0 and addr[1:0] is ignored.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   addr       in   byte address from the core (index = addr[ADDR_W+1:2])
//   writeData  in   store data
//   memWrite   in   store enable
//   finish     in   core-halted flag
//   readData   out  load data, mem[index], combinational
//   misaligned out  sticky misaligned-access flag
//   dump_busy  out  high while the signature scan runs
//   dump_done  out  high once the scan has completed
//   signature  out  scan result
// ----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter  int WORD   = WORD_W_DEFAULT,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WORD-1:0] addr,
  input  logic [WORD-1:0] writeData,
  input  logic            memWrite,
  input  logic            finish,
  output logic [WORD-1:0] readData,
  output logic            misaligned,
  output logic            dump_busy,
  output logic            dump_done,
  output logic [WORD-1:0] signature
);

  logic [WORD-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_scan_idx;
  logic [WORD-1:0]   w_scan_data;
  dump_state_t       w_state;
  logic              w_in_idle;
  logic              w_store_en;
  logic              w_unused_addr;

  // Upper bits drop out, so addresses alias modulo DEPTH*4.
  assign w_idx         = addr[ADDR_W+DMEM_BYTE_OFF_W-1:DMEM_BYTE_OFF_W];
  assign w_unused_addr = ^{addr[WORD-1:ADDR_W+DMEM_BYTE_OFF_W],
                           addr[DMEM_BYTE_OFF_W-1:0]};
  assign w_in_idle     = (w_state == IDLE);

  assign readData    = r_mem[w_idx];
  assign w_scan_data = r_mem[w_scan_idx];

`ifdef DMEM_ALIGN_CHECK_EN
  logic w_byte_off_nz;
  logic r_misaligned;

  assign w_byte_off_nz = |addr[DMEM_BYTE_OFF_W-1:0];
  assign w_store_en    = memWrite & w_in_idle & ~w_byte_off_nz;

  // Every IDLE cycle counts as a consumed read, so an offset address alone
  // is enough to flag it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misaligned <= 1'b0;
    end else if (w_in_idle && w_byte_off_nz) begin
      r_misaligned <= 1'b1;
    end
  end

  assign misaligned = r_misaligned;
`else
  assign w_store_en = memWrite & w_in_idle;
  assign misaligned = 1'b0;
`endif

  // NOTE: the array is deliberately left out of reset so it maps onto RAM;
  // contents survive rst_n, which the scan-after-reset flow relies on.
  always_ff @(posedge clk) begin
    if (w_store_en) begin
      r_mem[w_idx] <= writeData;
    end
  end

  dmem_sig_scanner #(
    .WORD  (WORD),
    .DEPTH (DEPTH)
  ) u_scanner (
    .clk       (clk),
    .rst_n     (rst_n),
    .finish    (finish),
    .rd_data   (w_scan_data),
    .rd_idx    (w_scan_idx),
    .state     (w_state),
    .dump_busy (dump_busy),
    .dump_done (dump_done),
    .signature (signature)
  );

endmodule
